// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery row engine and its scheduler.
// Contents: scheduler state enum, default S/NREQ, and width helpers for the
// row index and requester id.
package mont_pkg;

    localparam int S_DEF    = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_START,
        ST_WAIT,
        ST_NEXT,
        ST_FIN
    } state_t;

    // Row index needs one extra bit so it can also hold S itself.
    function automatic int row_w(input int s);
        return $clog2(s) + 1;
    endfunction

    // Requester id width, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among NREQ requesters.
// Ports:
//   req   : request vector
//   ptr   : highest-priority requester index (0..NREQ-1)
//   valid : at least one request present
//   gnt   : first set request at or above ptr, wrapping
module rr_arbiter
    import mont_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  gnt
);

    // Scan from the farthest offset down so the nearest one to ptr wins.
    always_comb begin
        valid = |req;
        gnt   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ])
                gnt = IDW'((int'(ptr) + i) % NREQ);
        end
    end

endmodule

// File: rtl/mont_row_sched.sv
// Scheduler owning one shared Montgomery row engine. Grants the engine
// round-robin to NREQ requesters and runs S rows per job
// (flush, start, wait-for-done), with a per-row watchdog and abort.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester job request (level, held until job end)
//   abort      : kill current job
//   grant_id   : owner of the engine (holds until next grant)
//   busy       : a job owns the engine
//   row_idx    : current outer-loop row
//   row_flush  : one-cycle flush to the row engine
//   row_start  : start, held until row_done is seen
//   row_done   : engine done (sticky until flushed)
//   job_done   : one-cycle pulse, job finished
//   job_err    : one-cycle pulse, job timed out or aborted
module mont_row_sched
    import mont_pkg::*;
#(
    parameter int S       = S_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = 64,
    parameter int IDW     = id_w(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic                abort,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic [row_w(S)-1:0] row_idx,
    output logic                row_flush,
    output logic                row_start,
    input  logic                row_done,
    output logic                job_done,
    output logic                job_err
);

    localparam int RW = row_w(S);
    localparam int WW = $clog2(TIMEOUT) + 1;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [WW-1:0]  wdog;
    logic           arb_valid;
    logic [IDW-1:0] arb_gnt;
    logic           active, timeout, kill, last_row;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    always_comb begin
        active   = (state == ST_FLUSH) || (state == ST_START) ||
                   (state == ST_WAIT)  || (state == ST_NEXT);
        // A row_done arriving in the last watchdog cycle still counts.
        timeout  = (state == ST_WAIT) && !row_done && (wdog == WW'(TIMEOUT - 1));
        kill     = active && (abort || timeout);
        last_row = (row_idx == RW'(S - 1));

        busy      = active;
        // Killed jobs flush the engine so a half-done row cannot leak.
        row_flush = (state == ST_FLUSH) || kill;
        row_start = ((state == ST_START) || ((state == ST_WAIT) && !row_done)) && !kill;
        job_err   = kill;
        job_done  = (state == ST_NEXT) && last_row && !abort;

        state_nx = state;
        case (state)
            ST_IDLE:  if (arb_valid) state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = kill ? ST_FIN : ST_START;
            ST_START: state_nx = kill ? ST_FIN : ST_WAIT;
            ST_WAIT: begin
                if (kill)          state_nx = ST_FIN;
                else if (row_done) state_nx = ST_NEXT;
            end
            ST_NEXT:  state_nx = (abort || last_row) ? ST_FIN : ST_FLUSH;
            ST_FIN:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            row_idx  <= '0;
            rr_ptr   <= '0;
            wdog     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_id <= arb_gnt;
                        row_idx  <= '0;
                    end
                end
                ST_START: wdog <= '0;
                ST_WAIT:  wdog <= wdog + WW'(1);
                ST_NEXT: begin
                    if (!abort && !last_row)
                        row_idx <= row_idx + RW'(1);
                end
                // Just-finished requester becomes lowest priority.
                ST_FIN: rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
                default: ;
            endcase
        end
    end

endmodule
